// File: rtl/rr_mux_reg.sv
// Packet-aware round-robin N:1 multiplexer with a registered output stage.
// A channel that starts a multi-beat packet keeps the output until its last beat is taken.
module rr_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [SELW-1:0]     ptr, ptr_nxt;
  logic [SELW-1:0]     lock_ch, lock_ch_nxt;
  logic [SELW-1:0]     win;
  logic [CHANNELS-1:0] grant;
  logic                found;
  int                  idx;
  logic                load, accept;
  logic [WIDTH-1:0]    win_data;
  logic                win_last;

  // The output register can take a new beat when empty or when it drains this cycle.
  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {CHANNELS{load & ~reset}};
  assign accept   = |in_ready;

  // Arbitration: rotate from ptr while idle, follow the owning channel while locked.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (state == LOCKED) begin
      win            = lock_ch;
      grant[lock_ch] = in_valid[lock_ch];
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!found && in_valid[idx]) begin
          found      = 1'b1;
          win        = idx[SELW-1:0];
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (win == SELW'(i)) begin
        win_data = in_data[i*WIDTH +: WIDTH];
        win_last = in_last[i];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    ptr_nxt     = ptr;
    case (state)
      IDLE:   if (accept && !win_last) begin
                state_nxt   = LOCKED;
                lock_ch_nxt = win;
              end
      LOCKED: if (accept && win_last) state_nxt = IDLE;
    endcase
    // Explicit wrap keeps ptr inside 0..CHANNELS-1 for non-power-of-two counts.
    if (accept && win_last)
      ptr_nxt = (win == SELW'(CHANNELS-1)) ? '0 : win + SELW'(1);
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lock_ch <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
      ptr     <= ptr_nxt;
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_last  <= win_last;
        out_sel   <= win;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
